// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester bridge: FSM state encoding,
// default bus widths, the Timer_8bit register map and a counter-width helper.
package apb_pkg;

    localparam int APB_ADDR_W = 2;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Timer_8bit register map
    localparam logic [1:0] TIMER_TDR = 2'b00;
    localparam logic [1:0] TIMER_TCR = 2'b01;
    localparam logic [1:0] TIMER_TSR = 2'b10;

    // Width needed to hold 0..timeout; never narrower than one bit.
    function automatic int tmo_cnt_width(input int timeout);
        if (timeout <= 0) begin
            return 1;
        end
        return ($clog2(timeout + 1) < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter. Cleared on entry to ACCESS, counts cycles with
// PREADY low, saturates instead of wrapping, and flags the abort cycle.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = tmo_cnt_width(TIMEOUT);
    localparam int LIMIT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;

    // Wait-cycle counter: clear has priority, then saturating increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // The abort cycle is the one where the count has reached TIMEOUT-1;
    // a zero TIMEOUT means the responder may stall forever.
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = (count_reg == CNT_W'(LIMIT));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: converts a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns read data, slave error and timeout status on a held
// response channel. One command in flight at a time; every output registered.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester side
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e state_reg;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    // Counter starts from zero on the SETUP->ACCESS edge and only advances
    // while the responder is inserting wait states.
    assign tmo_clr = (state_reg == ST_SETUP);
    assign tmo_en  = (state_reg == ST_ACCESS) && !PREADY;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (PCLK),
        .rst     (PRESET),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Transfer FSM with all bus and response outputs registered
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg   <= ST_IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // cmd_ready comes up one cycle after reset or a response
                    // handshake, so acceptance is qualified by the registered copy.
                    if (cmd_ready && cmd_valid) begin
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state_reg <= ST_SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    PENABLE   <= 1'b1;
                    state_reg <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // Normal completion is checked first so PREADY on the
                    // limit cycle still completes the transfer.
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state_reg   <= ST_RESP;
                    end else if (tmo_expired) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state_reg   <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
